// File: rtl/pa_fpu.sv
// Shared fpu definitions: opcode encoding plus the register map and bit positions
// of the CPU-side command sequencer window.
package pa_fpu;

    typedef enum logic [3:0] {
        op_add  = 4'h0,
        op_sub  = 4'h1,
        op_mul  = 4'h2,
        op_div  = 4'h3,
        op_sqrt = 4'h4,
        op_ftoi = 4'h5,
        op_itof = 4'h6
    } e_fpu_op;

    localparam logic [3:0] REG_A0   = 4'h0;
    localparam logic [3:0] REG_B0   = 4'h4;
    localparam logic [3:0] REG_OP   = 4'h8;
    localparam logic [3:0] REG_CTRL = 4'h9;
    localparam logic [3:0] REG_STAT = 4'hA;
    localparam logic [3:0] REG_R0   = 4'hC;

    localparam int unsigned CTRL_GO       = 0;
    localparam int unsigned CTRL_IRQ_EN   = 1;
    localparam int unsigned STAT_SEQ_BUSY = 0;
    localparam int unsigned STAT_DONE     = 1;
    localparam int unsigned STAT_ERR      = 2;
    localparam int unsigned STAT_TIMEOUT  = 3;
    localparam int unsigned STAT_FPU_BUSY = 4;

endpackage

// File: rtl/fpu_cmd_seq_regfile.sv
// Byte-wide register window for the fpu command sequencer: write decode with
// transaction lock, sticky status flags and a registered read mux.
module fpu_cmd_regfile
    import pa_fpu::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic [3:0]  addr,
    input  logic        wr,
    input  logic        rd,
    input  logic [7:0]  wr_data,
    input  logic        seq_busy,
    input  logic        fpu_busy,
    input  logic        done_set,
    input  logic        timeout_set,
    input  logic        result_we,
    input  logic [31:0] result,
    output logic [31:0] a_operand,
    output logic [31:0] b_operand,
    output logic [3:0]  opcode,
    output logic        go,
    output logic        irq_en,
    output logic        done,
    output logic [7:0]  rd_data
);

    logic [31:0] a_q, b_q, result_q;
    logic [3:0]  opcode_q;
    logic        irq_en_q, done_q, err_q, timeout_q;
    logic [7:0]  rd_data_q, rd_mux;
    logic        wr_lock, wr_ok, stat_wr;

    // Operand/opcode/ctrl writes are frozen while a transaction is in flight.
    assign wr_lock = wr && seq_busy && (addr <= REG_CTRL);
    assign wr_ok   = wr && !wr_lock;
    assign stat_wr = wr && (addr == REG_STAT);
    assign go      = wr_ok && (addr == REG_CTRL) && wr_data[CTRL_GO];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            a_q       <= '0;
            b_q       <= '0;
            opcode_q  <= '0;
            irq_en_q  <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            if (wr_ok) begin
                if (addr[3:2] == 2'b00) a_q[{addr[1:0], 3'b000} +: 8] <= wr_data;
                if (addr[3:2] == 2'b01) b_q[{addr[1:0], 3'b000} +: 8] <= wr_data;
                if (addr == REG_OP)     opcode_q <= wr_data[3:0];
                if (addr == REG_CTRL)   irq_en_q <= wr_data[CTRL_IRQ_EN];
            end
            if (result_we) result_q <= result;
            // Set beats a same-clock clear on every sticky flag.
            done_q    <= done_set | (done_q & ~(stat_wr & wr_data[STAT_DONE]));
            err_q     <= wr_lock | timeout_set | (err_q & ~(stat_wr & wr_data[STAT_ERR]));
            timeout_q <= timeout_set | (timeout_q & ~(stat_wr & wr_data[STAT_ERR]));
            if (rd) rd_data_q <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            4'h0, 4'h1, 4'h2, 4'h3: rd_mux = a_q[{addr[1:0], 3'b000} +: 8];
            4'h4, 4'h5, 4'h6, 4'h7: rd_mux = b_q[{addr[1:0], 3'b000} +: 8];
            REG_OP:                 rd_mux = {4'b0000, opcode_q};
            REG_CTRL:               rd_mux = {6'b000000, irq_en_q, 1'b0};
            REG_STAT:               rd_mux = {3'b000, fpu_busy, timeout_q, err_q, done_q, seq_busy};
            4'hC, 4'hD, 4'hE, 4'hF: rd_mux = result_q[{addr[1:0], 3'b000} +: 8];
            default:                rd_mux = '0;
        endcase
    end

    assign a_operand = a_q;
    assign b_operand = b_q;
    assign opcode    = opcode_q;
    assign irq_en    = irq_en_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;

endmodule

// File: rtl/fpu_cmd_seq.sv
// CPU-side initiator for the fpu start/cmd_end handshake: issues one operation per
// go, captures the result, and aborts with an error if the fpu never answers.
module fpu_cmd_seq
    import pa_fpu::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TMR_W          = 13
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [3:0]  addr,
    input  logic        wr,
    input  logic        rd,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        irq,
    output logic [31:0] a_operand,
    output logic [31:0] b_operand,
    output e_fpu_op     operation,
    output logic        start,
    input  logic [31:0] ieee_packet_out,
    input  logic        cmd_end,
    input  logic        busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam logic [TMR_W-1:0] TmrLimit = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pend_q, pend_d;
    logic             abort_q, abort_d;
    logic             irq_q;
    logic             go, irq_en, done, done_set, timeout_set, result_we;
    logic [3:0]       opcode;

    fpu_cmd_regfile u_regfile (
        .clk         (clk),
        .arst        (arst),
        .addr        (addr),
        .wr          (wr),
        .rd          (rd),
        .wr_data     (wr_data),
        .seq_busy    (state_q != StIdle),
        .fpu_busy    (busy),
        .done_set    (done_set),
        .timeout_set (timeout_set),
        .result_we   (result_we),
        .result      (ieee_packet_out),
        .a_operand   (a_operand),
        .b_operand   (b_operand),
        .opcode      (opcode),
        .go          (go),
        .irq_en      (irq_en),
        .done        (done),
        .rd_data     (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pend_d      = pend_q;
        abort_d     = abort_q;
        result_we   = 1'b0;
        timeout_set = 1'b0;
        done_set    = 1'b0;
        case (state_q)
            StIdle: begin
                if (go) begin
                    timer_d = '0;
                    abort_d = 1'b0;
                    // A stale cmd_end must fall before start may be raised.
                    if (cmd_end) begin
                        pend_d  = 1'b1;
                        state_d = StDrain;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (cmd_end) begin
                    result_we = 1'b1;
                    state_d   = StDrain;
                end else if (timer_q >= TmrLimit) begin
                    timeout_set = 1'b1;
                    abort_d     = 1'b1;
                    state_d     = StDrain;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDrain: begin
                if (!cmd_end) begin
                    if (pend_q) begin
                        pend_d  = 1'b0;
                        timer_d = '0;
                        state_d = StIssue;
                    end else begin
                        done_set = ~abort_q;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= StIdle;
            timer_q <= '0;
            pend_q  <= 1'b0;
            abort_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            abort_q <= abort_d;
            irq_q   <= done & irq_en;
        end
    end

    assign start     = (state_q == StIssue);
    assign irq       = irq_q;
    assign operation = e_fpu_op'(opcode);

endmodule

// File: tb/tb_fpu_cmd_seq.sv
// Directed bench for fpu_cmd_seq with a small behavioural fpu responder.
module tb_fpu_cmd_seq;
    import pa_fpu::*;

    logic        clk = 1'b0;
    logic        arst;
    logic [3:0]  addr;
    logic        wr, rd;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        irq;
    logic [31:0] a_operand, b_operand;
    e_fpu_op     operation;
    logic        start;
    logic [31:0] ieee_packet_out;
    logic        cmd_end;
    logic        busy;

    fpu_cmd_seq #(.TIMEOUT_CYCLES(64), .TMR_W(7)) dut (
        .clk             (clk),
        .arst            (arst),
        .addr            (addr),
        .wr              (wr),
        .rd              (rd),
        .wr_data         (wr_data),
        .rd_data         (rd_data),
        .irq             (irq),
        .a_operand       (a_operand),
        .b_operand       (b_operand),
        .operation       (operation),
        .start           (start),
        .ieee_packet_out (ieee_packet_out),
        .cmd_end         (cmd_end),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // fpu responder: raises cmd_end once start has been high for model_delay+1
    // clocks, then holds it for model_hold clocks after start drops.
    int   model_delay = 20;
    int   model_hold  = 0;
    int   cnt = 0, hcnt = 0;
    logic model_end = 1'b0;
    logic force_end = 1'b0;
    assign cmd_end = model_end | force_end;
    assign busy    = start;

    always @(posedge clk) begin
        #1;
        if (start) begin
            hcnt = 0;
            if (model_delay != 0 && !model_end) begin
                cnt++;
                if (cnt > model_delay) model_end = 1'b1;
            end
        end else begin
            cnt = 0;
            if (model_end) begin
                hcnt++;
                if (hcnt >= model_hold) begin
                    model_end = 1'b0;
                    hcnt = 0;
                end
            end
        end
    end

    int   start_cycles = 0;
    int   irq_rises = 0;
    int   bad_rises = 0;
    logic prev_start = 1'b0, prev_irq = 1'b0;
    always @(negedge clk) begin
        if (start) start_cycles++;
        if (irq && !prev_irq) irq_rises++;
        if (start && !prev_start && cmd_end) bad_rises++;
        prev_start = start;
        prev_irq   = irq;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        addr = a; wr_data = d; wr = 1'b1;
        tick(1);
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
        addr = a; rd = 1'b1;
        tick(1);
        rd = 1'b0;
        d = rd_data;
    endtask

    task automatic rd_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd_reg(a, d);
        check(name, {24'h0, d}, {24'h0, exp});
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic [7:0] s;
        s = 8'hFF;
        for (int i = 0; i < budget; i++) begin
            rd_reg(REG_STAT, s);
            if (!s[STAT_SEQ_BUSY]) break;
        end
        check(name, {31'h0, s[STAT_SEQ_BUSY]}, 32'h0);
    endtask

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 4'h0, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 4'h1, 8'h00, 8'h00};
        vecs[2]  = '{1'b1, 4'h2, 8'h80, 8'h80};
        vecs[3]  = '{1'b1, 4'h3, 8'h41, 8'h41};
        vecs[4]  = '{1'b1, 4'h4, 8'h00, 8'h00};
        vecs[5]  = '{1'b1, 4'h5, 8'h00, 8'h00};
        vecs[6]  = '{1'b1, 4'h6, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 4'h7, 8'h42, 8'h42};
        vecs[8]  = '{1'b1, 4'h8, 8'hF4, 8'h04};
        vecs[9]  = '{1'b1, 4'h9, 8'h02, 8'h02};
        vecs[10] = '{1'b0, 4'hB, 8'h00, 8'h00};

        arst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0;
        ieee_packet_out = 32'h4080_0000;
        tick(2);
        arst = 1'b0;
        tick(1);

        // Reset state
        check("rst_start", {31'h0, start}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_rd_data", {24'h0, rd_data}, 32'h0);
        check("rst_a", a_operand, 32'h0);
        rd_check("rst_status", REG_STAT, 8'h00);

        // Register window
        for (int i = 0; i < 11; i++) begin
            logic [7:0] d;
            if (vecs[i].we) wr_reg(vecs[i].addr, vecs[i].wdata);
            rd_reg(vecs[i].addr, d);
            check($sformatf("vec%0d_reg%h", i, vecs[i].addr), {24'h0, d}, {24'h0, vecs[i].exp});
        end
        check("a_operand", a_operand, 32'h4180_0000);
        check("b_operand", b_operand, 32'h4200_0000);
        check("operation", 32'(operation), 32'(op_sqrt));

        // Normal sqrt transaction with a locked write mid-flight
        start_cycles = 0;
        wr_reg(REG_CTRL, 8'h03);
        wr_reg(4'h0, 8'hFF);
        check("lock_a", a_operand, 32'h4180_0000);
        rd_check("lock_status_err", REG_STAT, 8'h15);
        wr_reg(REG_STAT, 8'h04);
        rd_check("lock_status_clr", REG_STAT, 8'h11);
        wait_idle("op1_idle", 100);
        check("op1_start_cycles", start_cycles, 21);
        rd_check("op1_status", REG_STAT, 8'h02);
        rd_check("op1_r0", 4'hC, 8'h00);
        rd_check("op1_r1", 4'hD, 8'h00);
        rd_check("op1_r2", 4'hE, 8'h80);
        rd_check("op1_r3", 4'hF, 8'h40);
        check("op1_irq", {31'h0, irq}, 32'h1);

        // cmd_end held after completion; go rewritten while draining
        wr_reg(REG_STAT, 8'h02);
        tick(2);
        irq_rises = 0;
        start_cycles = 0;
        model_hold = 10;
        ieee_packet_out = 32'h1234_5678;
        wr_reg(REG_CTRL, 8'h03);
        for (int n = 0; n < 100 && start; n++) tick(1);
        check("hold_start_fell", {31'h0, start}, 32'h0);
        check("hold_cmd_end_high", {31'h0, cmd_end}, 32'h1);
        wr_reg(REG_CTRL, 8'h03);
        tick(20);
        check("hold_start_cycles", start_cycles, 21);
        check("hold_one_done", irq_rises, 1);
        rd_check("hold_status", REG_STAT, 8'h06);
        rd_check("hold_r3", 4'hF, 8'h12);
        rd_check("hold_r0", 4'hC, 8'h78);

        // go accepted with stale cmd_end high in IDLE
        wr_reg(REG_STAT, 8'h06);
        start_cycles = 0;
        force_end = 1'b1;
        wr_reg(REG_CTRL, 8'h03);
        tick(3);
        check("stale_no_start", {31'h0, start}, 32'h0);
        rd_check("stale_status_busy", REG_STAT, 8'h01);
        force_end = 1'b0;
        wait_idle("stale_idle", 200);
        check("stale_start_cycles", start_cycles, 21);
        rd_check("stale_status", REG_STAT, 8'h02);
        check("no_start_over_cmd_end", bad_rises, 0);

        // Timeout: fpu never answers
        wr_reg(REG_STAT, 8'h06);
        model_delay = 0;
        ieee_packet_out = 32'hDEAD_BEEF;
        start_cycles = 0;
        wr_reg(REG_CTRL, 8'h03);
        wait_idle("to_idle", 200);
        check("to_start_cycles", start_cycles, 64);
        rd_check("to_status", REG_STAT, 8'h0C);
        check("to_irq", {31'h0, irq}, 32'h0);
        rd_check("to_r0_kept", 4'hC, 8'h78);
        rd_check("to_r3_kept", 4'hF, 8'h12);
        wr_reg(REG_STAT, 8'h04);
        rd_check("to_status_clr", REG_STAT, 8'h00);

        // Set wins over a same-clock done clear
        wr_reg(REG_CTRL, 8'h03);
        tick(2);
        force_end = 1'b1;
        tick(1);
        force_end = 1'b0;
        tick(2);
        rd_check("sw_pre_done", REG_STAT, 8'h02);
        wr_reg(REG_CTRL, 8'h03);
        tick(2);
        force_end = 1'b1;
        tick(1);
        force_end = 1'b0;
        wr_reg(REG_STAT, 8'h02);
        rd_check("sw_done_wins", REG_STAT, 8'h02);
        wr_reg(REG_STAT, 8'h02);
        rd_check("sw_done_clr", REG_STAT, 8'h00);

        // Asynchronous reset mid-ISSUE
        model_delay = 20;
        model_hold = 0;
        ieee_packet_out = 32'h4080_0000;
        wr_reg(REG_CTRL, 8'h03);
        tick(5);
        check("ar_start_pre", {31'h0, start}, 32'h1);
        arst = 1'b1;
        #1;
        check("ar_start_async", {31'h0, start}, 32'h0);
        #1;
        arst = 1'b0;
        tick(1);
        check("ar_a_cleared", a_operand, 32'h0);
        check("ar_irq", {31'h0, irq}, 32'h0);
        rd_check("ar_status", REG_STAT, 8'h00);
        rd_check("ar_r3", 4'hF, 8'h00);
        start_cycles = 0;
        wr_reg(REG_CTRL, 8'h03);
        wait_idle("ar_idle", 100);
        check("ar_start_cycles", start_cycles, 21);
        rd_check("ar_status_done", REG_STAT, 8'h02);
        rd_check("ar_r3_new", 4'hF, 8'h40);
        check("ar_irq_done", {31'h0, irq}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_cmd_seq.md
Name: fpu_cmd_seq

Overview:
- CPU-side initiator for the fpu start/cmd_end/busy protocol; the other end of the handshake that the fpu responds to.
- Presents an 8-bit register window to the Sol-1 data bus: operand bytes, opcode and go command in; result, status and irq out.
- Holds operands and opcode stable, raises start, waits for cmd_end, captures ieee_packet_out and flags completion. A timeout guards against a hung fpu.

Parameters:
- TIMEOUT_CYCLES, 4096: clocks spent in ISSUE without cmd_end before the operation is aborted with an error.
- TMR_W, 13: timeout counter width; must satisfy 2**TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous reset, active-high
- addr  in  4  register index
- wr  in  1  write strobe, one clk per access
- rd  in  1  read strobe, one clk per access
- wr_data  in  8  write data
- rd_data  out  8  read data, registered
- irq  out  1  completion interrupt, level
- a_operand  out  32  to fpu
- b_operand  out  32  to fpu
- operation  out  pa_fpu::e_fpu_op  to fpu
- start  out  1  to fpu
- ieee_packet_out  in  32  fpu result
- cmd_end  in  1  fpu completion
- busy  in  1  fpu busy, status mirror only

Behaviour:
- Register map (multi-byte values are little-endian):
  - 0-3: A bytes 0..3 (RW)
  - 4-7: B bytes 0..3 (RW)
  - 8: opcode, bits[3:0] (RW)
  - 9: CTRL. Write bit0=go (self-clearing, reads 0); bit1=irq_en (RW).
  - A: STATUS. Read: bit0 seq_busy, bit1 done, bit2 err, bit3 timeout, bit4 fpu busy. Write 1 to bit1 clears done; write 1 to bit2 clears err and timeout.
  - C-F: result bytes 0..3 (RO)
  - B: reads 0.
- rd_data is valid the clk after rd is sampled and holds until the next rd.
- Reset values: all registers 0, start=0, irq=0, rd_data=0, state IDLE.
- FSM transitions:
  - IDLE: go=1 -> ISSUE, start=1 from the next clk, timer cleared.
  - ISSUE: cmd_end=1 -> capture ieee_packet_out into the result registers, start=0 next clk, -> DRAIN.
  - ISSUE: timer reaches TIMEOUT_CYCLES -> start=0, set timeout and err, -> DRAIN. Result is not updated.
  - DRAIN: wait for cmd_end=0, then set done (on success only) and -> IDLE.
- start is driven only in ISSUE, so it is never reasserted while cmd_end is still high.
- seq_busy = (state != IDLE).
- Any write to regs 0-9 while seq_busy is ignored and sets err; operands and opcode stay frozen for the whole transaction.
- go while seq_busy: ignored, err set.
- go with cmd_end already high in IDLE: accepted; ISSUE waits for a fresh assertion only after DRAIN has seen cmd_end low. A stale cmd_end therefore can never complete a new op.
- Same-clk set and clear of done or err: set wins.
- irq = done & irq_en, registered (one clk after done sets).
- arst mid-operation: immediate return to reset values, start drops asynchronously, captured result is lost.
- Timer is TMR_W bits and saturates; it never wraps.

Decomposition:
- pa_fpu (shared package): e_fpu_op, plus new register-index localparams (REG_A0, REG_B0, REG_OP, REG_CTRL, REG_STAT, REG_R0) and the STATUS/CTRL bit positions. The fpu bench and CPU microcode generator reuse these.
- Sub-module fpu_cmd_regfile: byte write decode, write-lock and err generation, registered read mux. The FSM and timer stay in fpu_cmd_seq.

Test Plan:
- Write A=0x41800000, B=0x42000000, op=op_sqrt, go; model asserts cmd_end after 20 clks with result 0x40800000 -> start high for 21 clks, then low; done=1; regs C-F read 00,00,80,40; irq=1 when irq_en=1.
- Write reg 0 = 0xFF while seq_busy -> a_operand unchanged at 0x41800000; STATUS reads err=1; writing 0x04 to STATUS clears err.
- Model never asserts cmd_end, TIMEOUT_CYCLES=64 -> start drops after 64 clks; STATUS=0x0C; done=0; result registers unchanged.
- cmd_end held high for 10 clks after completion, go rewritten immediately -> second start is not issued until cmd_end falls and DRAIN exits; exactly one done per go.
- Pulse arst mid-ISSUE -> start=0 asynchronously; all STATUS bits 0; a subsequent go works normally.
- Set done and write STATUS bit1 in the same clk as a new completion -> done reads 1 (set wins).
